commutator_seq_ctrl: RTL and testbench

//  Frame sequencer for the radix-4 commutator chain of the FFT pipeline.
//  - Accepts beats from the input side and checks framing.
//  - Issues one start pulse per commutator stage, aligned to when that stage's frame

---
 rtl/commutator_seq_ctrl.sv | 100 ++++++++++
 tb/tb_commutator_seq_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/commutator_seq_ctrl.sv
// commutator_seq_ctrl: frame sequencer that checks input framing, issues per-stage start
// pulses for the radix-4 commutator chain and regenerates valid/sop at the chain output
module commutator_seq_ctrl #(
    parameter int                  NSTAGE        = 3,
    parameter int                  FRAME_LEN     = 8,
    parameter logic [8*NSTAGE-1:0] STAGE_LAT_VEC = {8'd6, 8'd6, 8'd6}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic [NSTAGE-1:0] stage_start,
    output logic              out_valid,
    output logic              out_sop,
    output logic              busy,
    output logic [3:0]        frames_inflight,
    output logic              err,
    input  logic              err_clr
);
    function automatic int cum_lat(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s += int'(STAGE_LAT_VEC[8*i +: 8]);
        return s;
    endfunction

    localparam int TOTAL_LAT = cum_lat(NSTAGE);

    typedef enum logic {IDLE, RECV} state_t;

    state_t               state, state_nxt;
    logic [2:0]           beat_cnt, beat_cnt_nxt;
    logic                 acc_sop, acc_valid, err_set;
    logic [TOTAL_LAT-1:0] sop_line, valid_line;

    assign acc_sop   = reset_n & in_valid & in_sop;
    assign acc_valid = in_valid & (in_sop | (state == RECV));

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        err_set      = 1'b0;
        if (state == IDLE) begin
            if (in_valid & in_sop) begin
                state_nxt    = RECV;
                beat_cnt_nxt = 3'd1;
            end else if (in_valid) begin
                err_set = 1'b1;
            end
        end else if (!in_valid) begin
            err_set      = 1'b1;
            state_nxt    = IDLE;
            beat_cnt_nxt = 3'd0;
        end else if (in_sop) begin
            err_set      = 1'b1;
            beat_cnt_nxt = 3'd1;
        end else if (beat_cnt == 3'(FRAME_LEN - 1)) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = 3'd0;
        end else begin
            beat_cnt_nxt = beat_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            beat_cnt        <= 3'd0;
            sop_line        <= '0;
            valid_line      <= '0;
            err             <= 1'b0;
            frames_inflight <= 4'd0;
        end else begin
            state           <= state_nxt;
            beat_cnt        <= beat_cnt_nxt;
            sop_line        <= TOTAL_LAT'({sop_line, acc_sop});
            valid_line      <= TOTAL_LAT'({valid_line, acc_valid});
            err             <= err_set | (err & ~err_clr);
            frames_inflight <= (acc_sop & ~out_sop & (frames_inflight != 4'd15)) ? frames_inflight + 4'd1 :
                               (out_sop & ~acc_sop & (frames_inflight != 4'd0))  ? frames_inflight - 4'd1 :
                               frames_inflight;
        end
    end

    assign stage_start[0] = acc_sop;

    // sop_line[i] carries the sop token delayed by i+1 cycles
    for (genvar k = 1; k < NSTAGE; k++) begin : g_tap
        localparam int D = cum_lat(k);
        if (D == 0) begin : g_comb
            assign stage_start[k] = acc_sop;
        end else begin : g_reg
            assign stage_start[k] = sop_line[D-1];
        end
    end

    assign out_sop   = sop_line[TOTAL_LAT-1];
    assign out_valid = valid_line[TOTAL_LAT-1];
    assign busy      = (state == RECV) | (frames_inflight != 4'd0);
endmodule

// File: tb/tb_commutator_seq_ctrl.sv
// tb_commutator_seq_ctrl: directed bench with hand-computed per-cycle expectations
module tb_commutator_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] stage_start;
    logic       out_valid, out_sop, busy, err;
    logic [3:0] frames_inflight;
    logic [10:0] obs;
    int passed = 0;
    int total = 0;

    commutator_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
        .stage_start(stage_start), .out_valid(out_valid), .out_sop(out_sop),
        .busy(busy), .frames_inflight(frames_inflight), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    assign obs = {stage_start, out_valid, out_sop, busy, frames_inflight, err};

    function automatic logic [10:0] pk(input logic [2:0] ss, input logic ov, input logic os,
                                       input logic bz, input int fi, input logic e);
        return {ss, ov, os, bz, 4'(fi), e};
    endfunction

    function automatic bit at3(input int t, input int a, input int b, input int c);
        return (t == a) || (t == b) || (t == c);
    endfunction

    function automatic int cnt_lt(input int t, input int a, input int b, input int c);
        return (a < t ? 1 : 0) + (b < t ? 1 : 0) + (c < t ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed ss/ov/os/busy/fi/err=%b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("reset_state", 11'd0);
        tick();
        reset_n = 1'b1;
        // single frame, sop at 10
        for (int t = 0; t <= 40; t++) begin
            in_valid = (t >= 10 && t <= 17);
            in_sop   = (t == 10);
            #2;
            chk($sformatf("single@%0d", t),
                pk({t == 22, t == 16, t == 10}, t >= 28 && t <= 35, t == 28, t >= 11 && t <= 28,
                   cnt_lt(t, 10, 9999, 9999) - cnt_lt(t, 28, 9999, 9999), 1'b0));
            tick();
        end
        // three back-to-back frames
        for (int t = 0; t <= 45; t++) begin
            in_valid = (t <= 23);
            in_sop   = at3(t, 0, 8, 16);
            #2;
            chk($sformatf("b2b@%0d", t),
                pk({at3(t, 12, 20, 28), at3(t, 6, 14, 22), at3(t, 0, 8, 16)},
                   t >= 18 && t <= 41, at3(t, 18, 26, 34), t >= 1 && t <= 34,
                   cnt_lt(t, 0, 8, 16) - cnt_lt(t, 18, 26, 34), 1'b0));
            tick();
        end
        // gap at beat 3, then err_clr
        for (int t = 0; t <= 30; t++) begin
            in_valid = (t >= 2 && t <= 4);
            in_sop   = (t == 2);
            err_clr  = (t == 25);
            #2;
            chk($sformatf("gap@%0d", t),
                pk({t == 14, t == 8, t == 2}, t >= 20 && t <= 22, t == 20, t >= 3 && t <= 20,
                   cnt_lt(t, 2, 9999, 9999) - cnt_lt(t, 20, 9999, 9999), t >= 6 && t <= 25));
            tick();
        end
        // sop at beat 5 restarts the frame
        for (int t = 0; t <= 45; t++) begin
            in_valid = (t >= 2 && t <= 14);
            in_sop   = (t == 2) || (t == 7);
            err_clr  = (t == 40);
            #2;
            chk($sformatf("midsop@%0d", t),
                pk({at3(t, 14, 19, -1), at3(t, 8, 13, -1), at3(t, 2, 7, -1)},
                   t >= 20 && t <= 32, at3(t, 20, 25, -1), t >= 3 && t <= 25,
                   cnt_lt(t, 2, 7, 9999) - cnt_lt(t, 20, 25, 9999), t >= 8 && t <= 40));
            tick();
        end
        // stray beats; err_clr with a simultaneous stray beat keeps err
        for (int t = 0; t <= 30; t++) begin
            in_valid = (t == 2) || (t == 5);
            in_sop   = 1'b0;
            err_clr  = (t == 5) || (t == 8);
            #2;
            chk($sformatf("stray@%0d", t), pk(3'b000, 1'b0, 1'b0, 1'b0, 0, t >= 3 && t <= 8));
            tick();
        end
        err_clr = 1'b0;
        // reset in the middle of a frame
        for (int t = 0; t <= 5; t++) begin
            in_valid = (t == 0) || (t >= 2);
            in_sop   = (t == 2);
            #2;
            chk($sformatf("prerst@%0d", t),
                pk({2'b00, t == 2}, 1'b0, 1'b0, t >= 3, t >= 3 ? 1 : 0, t >= 1));
            tick();
        end
        in_valid = 1'b1;
        in_sop   = 1'b0;
        #2;
        chk("pre_reset", pk(3'b000, 1'b0, 1'b0, 1'b1, 1, 1'b1));
        reset_n = 1'b0;
        in_sop  = 1'b1;
        #1;
        chk("reset_async", 11'd0);
        tick();
        chk("reset_held", 11'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        for (int t = 0; t <= 25; t++) begin
            in_valid = (t >= 2 && t <= 9);
            in_sop   = (t == 2);
            #2;
            chk($sformatf("postrst@%0d", t),
                pk({t == 14, t == 8, t == 2}, t >= 20 && t <= 27, t == 20, t >= 3 && t <= 20,
                   cnt_lt(t, 2, 9999, 9999) - cnt_lt(t, 20, 9999, 9999), 1'b0));
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
